// File: rtl/i2c_target.sv
// I2C target responder: START/STOP detection, 7-bit address match,
// write bytes streamed out, read bytes fetched on request. Open-drain SDA.
module i2c_target #(
    parameter logic [6:0] TARGET_ADDR = 7'h3C,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic [7:0] wr_data,
    output logic       wr_valid,
    output logic       rd_req,
    input  logic [7:0] rd_data,
    output logic       busy
);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_ADDR     = 3'd1;
    localparam logic [2:0] ST_ADDR_ACK = 3'd2;
    localparam logic [2:0] ST_WR_BYTE  = 3'd3;
    localparam logic [2:0] ST_WR_ACK   = 3'd4;
    localparam logic [2:0] ST_RD_BYTE  = 3'd5;
    localparam logic [2:0] ST_RD_ACK   = 3'd6;
    localparam logic [2:0] ST_IGNORE   = 3'd7;

    logic [SYNC_STAGES-1:0] r_scl_sync;
    logic [SYNC_STAGES-1:0] r_sda_sync;
    logic                   r_scl_hist;
    logic                   r_sda_hist;

    logic [2:0] r_state;
    logic [2:0] r_cnt;
    logic [7:0] r_shift;
    logic       r_rw;
    // Second phase of a byte: ACK driven / byte done / master ACK seen
    logic       r_flag;

    logic       w_scl;
    logic       w_sda;
    logic       w_scl_rise;
    logic       w_scl_fall;
    logic       w_start;
    logic       w_stop;
    logic [7:0] w_shift_in;
    logic       w_addr_hit;

    assign w_scl      = r_scl_sync[SYNC_STAGES-1];
    assign w_sda      = r_sda_sync[SYNC_STAGES-1];
    assign w_scl_rise = w_scl & ~r_scl_hist;
    assign w_scl_fall = ~w_scl & r_scl_hist;
    assign w_start    = w_scl & r_sda_hist & ~w_sda;
    assign w_stop     = w_scl & ~r_sda_hist & w_sda;
    assign w_shift_in = {r_shift[6:0], w_sda};
    assign w_addr_hit = (w_shift_in[7:1] == TARGET_ADDR);

    // Idle bus is high, so the synchronizers reset to 1 to avoid fake edges
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_scl_sync <= '1;
            r_sda_sync <= '1;
            r_scl_hist <= 1'b1;
            r_sda_hist <= 1'b1;
        end else begin
            r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], scl_in};
            r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sda_in};
            r_scl_hist <= w_scl;
            r_sda_hist <= w_sda;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= ST_IDLE;
            r_cnt    <= 3'd0;
            r_shift  <= 8'h00;
            r_rw     <= 1'b0;
            r_flag   <= 1'b0;
            sda_oe   <= 1'b0;
            wr_data  <= 8'h00;
            wr_valid <= 1'b0;
            rd_req   <= 1'b0;
            busy     <= 1'b0;
        end else begin
            wr_valid <= 1'b0;
            rd_req   <= 1'b0;
            if (rd_req) begin
                r_shift <= rd_data;
            end
            if (w_start) begin
                r_state <= ST_ADDR;
                r_cnt   <= 3'd0;
                r_flag  <= 1'b0;
                sda_oe  <= 1'b0;
                busy    <= 1'b1;
            end else if (w_stop) begin
                r_state <= ST_IDLE;
                r_cnt   <= 3'd0;
                r_flag  <= 1'b0;
                sda_oe  <= 1'b0;
                busy    <= 1'b0;
            end else begin
                case (r_state)
                    ST_ADDR: begin
                        if (w_scl_rise) begin
                            r_shift <= w_shift_in;
                            r_cnt   <= r_cnt + 3'd1;
                            if (r_cnt == 3'd7) begin
                                r_rw    <= w_sda;
                                r_flag  <= 1'b0;
                                r_state <= w_addr_hit ? ST_ADDR_ACK
                                                      : ST_IGNORE;
                            end
                        end
                    end
                    ST_ADDR_ACK: begin
                        if (w_scl_fall && !r_flag) begin
                            sda_oe <= 1'b1;
                            r_flag <= 1'b1;
                        end else if (w_scl_fall) begin
                            r_flag <= 1'b0;
                            r_cnt  <= 3'd0;
                            if (r_rw) begin
                                sda_oe  <= ~r_shift[7];
                                r_state <= ST_RD_BYTE;
                            end else begin
                                sda_oe  <= 1'b0;
                                r_state <= ST_WR_BYTE;
                            end
                        end else if (w_scl_rise && r_flag && r_rw) begin
                            rd_req <= 1'b1;
                        end
                    end
                    ST_WR_BYTE: begin
                        if (w_scl_rise && !r_flag) begin
                            r_shift <= w_shift_in;
                            r_cnt   <= r_cnt + 3'd1;
                            if (r_cnt == 3'd7) begin
                                wr_data  <= w_shift_in;
                                wr_valid <= 1'b1;
                                r_flag   <= 1'b1;
                            end
                        end else if (w_scl_fall && r_flag) begin
                            sda_oe  <= 1'b1;
                            r_flag  <= 1'b0;
                            r_state <= ST_WR_ACK;
                        end
                    end
                    ST_WR_ACK: begin
                        if (w_scl_fall) begin
                            sda_oe  <= 1'b0;
                            r_cnt   <= 3'd0;
                            r_state <= ST_WR_BYTE;
                        end
                    end
                    ST_RD_BYTE: begin
                        if (w_scl_fall) begin
                            if (r_cnt == 3'd7) begin
                                sda_oe  <= 1'b0;
                                r_cnt   <= 3'd0;
                                r_flag  <= 1'b0;
                                r_state <= ST_RD_ACK;
                            end else begin
                                sda_oe  <= ~r_shift[6];
                                r_shift <= {r_shift[6:0], 1'b0};
                                r_cnt   <= r_cnt + 3'd1;
                            end
                        end
                    end
                    ST_RD_ACK: begin
                        if (w_scl_rise && !r_flag) begin
                            if (w_sda) begin
                                sda_oe  <= 1'b0;
                                r_state <= ST_IGNORE;
                            end else begin
                                rd_req <= 1'b1;
                                r_flag <= 1'b1;
                            end
                        end else if (w_scl_fall && r_flag) begin
                            sda_oe  <= ~r_shift[7];
                            r_flag  <= 1'b0;
                            r_cnt   <= 3'd0;
                            r_state <= ST_RD_BYTE;
                        end
                    end
                    ST_IGNORE: begin
                        sda_oe <= 1'b0;
                    end
                    default: begin
                        sda_oe <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_target.sv
// Directed bench for i2c_target: bus-master tasks drive SCL/SDA,
// a scoreboard queue holds expected write bytes and read bytes.
module tb_i2c_target;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic [7:0] rd_data = 8'h00;
    logic       sda_oe;
    logic [7:0] wr_data;
    logic       wr_valid;
    logic       rd_req;
    logic       busy;
    wire        sda_line = sda_m & ~sda_oe;

    i2c_target #(
        .TARGET_ADDR(7'h3C),
        .SYNC_STAGES(2)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .scl_in  (scl_m),
        .sda_in  (sda_line),
        .sda_oe  (sda_oe),
        .wr_data (wr_data),
        .wr_valid(wr_valid),
        .rd_req  (rd_req),
        .rd_data (rd_data),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;
    int n_wv = 0;
    int n_rq = 0;
    int n_ovl = 0;
    int n_oe = 0;
    logic [7:0] exp_wr[$];
    logic [7:0] rd_src[$];
    logic [7:0] exp_rd[$];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    always @(negedge clk) begin
        if (sda_oe) n_oe++;
        if (wr_valid && rd_req) n_ovl++;
        if (rd_req) begin
            n_rq++;
            if (rd_src.size() > 0) rd_data = rd_src.pop_front();
            else rd_data = 8'hEE;
        end
        if (wr_valid) begin
            n_wv++;
            chk("wr_expected", 32'(exp_wr.size() > 0), 1);
            if (exp_wr.size() > 0) chk("wr_data", wr_data, exp_wr.pop_front());
        end
    end

    task automatic qwait();
        repeat (25) @(posedge clk);
        #1;
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; scl_m = 1'b1; qwait();
        sda_m = 1'b0; qwait();
        scl_m = 1'b0; qwait();
    endtask

    task automatic i2c_rstart();
        sda_m = 1'b1; qwait();
        scl_m = 1'b1; qwait();
        sda_m = 1'b0; qwait();
        scl_m = 1'b0; qwait();
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; qwait();
        scl_m = 1'b1; qwait();
        sda_m = 1'b1; qwait();
    endtask

    task automatic clk_bit(input logic b, output logic s);
        sda_m = b; qwait();
        scl_m = 1'b1; qwait();
        s = sda_line; qwait();
        scl_m = 1'b0; qwait();
    endtask

    task automatic wr_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) clk_bit(b[i], s);
        clk_bit(1'b1, ack);
    endtask

    task automatic rd_byte(input logic nack, output logic [7:0] b);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            clk_bit(1'b1, s);
            b[i] = s;
        end
        clk_bit(nack, s);
    endtask

    initial begin
        logic       a;
        logic [7:0] b;
        logic       s;
        int         wv0;
        int         rq0;
        int         oe0;

        repeat (5) @(posedge clk);
        #1;
        chk("rst_sda_oe", sda_oe, 0);
        chk("rst_wr_valid", wr_valid, 0);
        chk("rst_rd_req", rd_req, 0);
        chk("rst_busy", busy, 0);
        chk("rst_wr_data", wr_data, 8'h00);
        rst = 1'b1;
        repeat (5) @(posedge clk);

        // 1: write two bytes
        wv0 = n_wv;
        i2c_start();
        chk("t1_busy", busy, 1);
        wr_byte(8'h78, a); chk("t1_ack_addr", a, 0);
        exp_wr.push_back(8'hA5);
        wr_byte(8'hA5, a); chk("t1_ack_d0", a, 0);
        exp_wr.push_back(8'h5A);
        wr_byte(8'h5A, a); chk("t1_ack_d1", a, 0);
        i2c_stop();
        chk("t1_busy_end", busy, 0);
        chk("t1_wv_cnt", n_wv - wv0, 2);

        // 2: foreign address is ignored
        wv0 = n_wv;
        oe0 = n_oe;
        i2c_start();
        wr_byte(8'h44, a); chk("t2_nack_addr", a, 1);
        wr_byte(8'h11, a); chk("t2_nack_data", a, 1);
        chk("t2_busy", busy, 1);
        i2c_stop();
        chk("t2_oe_cnt", n_oe - oe0, 0);
        chk("t2_wv_cnt", n_wv - wv0, 0);
        chk("t2_busy_end", busy, 0);

        // 3: read two bytes, ACK then NACK
        rq0 = n_rq;
        rd_src.push_back(8'hC3); exp_rd.push_back(8'hC3);
        rd_src.push_back(8'h81); exp_rd.push_back(8'h81);
        i2c_start();
        wr_byte(8'h79, a); chk("t3_ack_addr", a, 0);
        rd_byte(1'b0, b); chk("t3_rd0", b, exp_rd.pop_front());
        rd_byte(1'b1, b); chk("t3_rd1", b, exp_rd.pop_front());
        chk("t3_oe_nack", sda_oe, 0);
        i2c_stop();
        chk("t3_rq_cnt", n_rq - rq0, 2);
        chk("t3_src_empty", rd_src.size(), 0);

        // 4: write, repeated START, read
        wv0 = n_wv;
        rq0 = n_rq;
        exp_wr.push_back(8'h10);
        rd_src.push_back(8'h6E); exp_rd.push_back(8'h6E);
        i2c_start();
        wr_byte(8'h78, a); chk("t4_ack_w", a, 0);
        wr_byte(8'h10, a); chk("t4_ack_d", a, 0);
        i2c_rstart();
        chk("t4_busy_sr", busy, 1);
        wr_byte(8'h79, a); chk("t4_ack_r", a, 0);
        rd_byte(1'b1, b); chk("t4_rd", b, exp_rd.pop_front());
        i2c_stop();
        chk("t4_wv_cnt", n_wv - wv0, 1);
        chk("t4_rq_cnt", n_rq - rq0, 1);

        // 5: asynchronous reset while driving a 0 read bit
        rd_src.push_back(8'h3F);
        i2c_start();
        wr_byte(8'h79, a); chk("t5_ack_addr", a, 0);
        chk("t5_drive0", sda_oe, 1);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("t5_oe_rst", sda_oe, 0);
        chk("t5_busy_rst", busy, 0);
        scl_m = 1'b1;
        sda_m = 1'b1;
        repeat (5) @(posedge clk);
        rst = 1'b1;
        rd_src.delete();
        repeat (5) @(posedge clk);
        wv0 = n_wv;
        exp_wr.push_back(8'h9C);
        i2c_start();
        wr_byte(8'h78, a); chk("t5_ack_w", a, 0);
        wr_byte(8'h9C, a); chk("t5_ack_d", a, 0);
        i2c_stop();
        chk("t5_wv_cnt", n_wv - wv0, 1);

        // 6: STOP in the middle of a write byte
        wv0 = n_wv;
        i2c_start();
        wr_byte(8'h78, a); chk("t6_ack_addr", a, 0);
        clk_bit(1'b1, s);
        clk_bit(1'b0, s);
        clk_bit(1'b1, s);
        clk_bit(1'b1, s);
        i2c_stop();
        chk("t6_busy", busy, 0);
        chk("t6_wv_partial", n_wv - wv0, 0);
        exp_wr.push_back(8'h33);
        i2c_start();
        chk("t6_busy_restart", busy, 1);
        wr_byte(8'h78, a); chk("t6_ack_w", a, 0);
        wr_byte(8'h33, a); chk("t6_ack_d", a, 0);
        i2c_stop();
        chk("t6_wv_cnt", n_wv - wv0, 1);

        chk("end_wr_queue", exp_wr.size(), 0);
        chk("end_overlap", n_ovl, 0);
        chk("end_oe_idle", sda_oe, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
